// File: rtl/gfx_raster_cmd_sched.sv
// Draw-command scheduler: queues point/rect/line/triangle commands and issues them one at a time
// on the rasterizer's level-held write inputs, with a forced low cycle after each ack.
module gfx_raster_cmd_sched #(
  parameter int unsigned point_width    = 16,
  parameter int unsigned subpixel_width = 16,
  parameter int unsigned fifo_depth     = 4,
  parameter int unsigned timeout_cycles = 65535
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  cmd_valid_i,
  output logic                                  cmd_ready_o,
  input  logic [2:0]                            cmd_op_i,
  input  logic [point_width+subpixel_width-1:0] cmd_p0x_i,
  input  logic [point_width+subpixel_width-1:0] cmd_p0y_i,
  input  logic [point_width+subpixel_width-1:0] cmd_p1x_i,
  input  logic [point_width+subpixel_width-1:0] cmd_p1y_i,
  input  logic [point_width+subpixel_width-1:0] cmd_p2x_i,
  input  logic [point_width+subpixel_width-1:0] cmd_p2y_i,
  input  logic                                  flush_i,
  input  logic                                  err_clr_i,
  output logic                                  point_write_o,
  output logic                                  rect_write_o,
  output logic                                  line_write_o,
  output logic                                  triangle_write_o,
  output logic [point_width+subpixel_width-1:0] dest_pixel0_x_o,
  output logic [point_width+subpixel_width-1:0] dest_pixel0_y_o,
  output logic [point_width+subpixel_width-1:0] dest_pixel1_x_o,
  output logic [point_width+subpixel_width-1:0] dest_pixel1_y_o,
  output logic [point_width+subpixel_width-1:0] dest_pixel2_x_o,
  output logic [point_width+subpixel_width-1:0] dest_pixel2_y_o,
  input  logic                                  raster_ack_i,
  output logic                                  busy_o,
  output logic [$clog2(fifo_depth):0]           fifo_level_o,
  output logic [15:0]                           done_cnt_o,
  output logic                                  err_illegal_o,
  output logic                                  err_timeout_o
);

  localparam int unsigned CW  = point_width + subpixel_width;
  localparam int unsigned AW  = $clog2(fifo_depth);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned WDW = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);

  typedef struct packed {
    logic [CW-1:0] p0x;
    logic [CW-1:0] p0y;
    logic [CW-1:0] p1x;
    logic [CW-1:0] p1y;
    logic [CW-1:0] p2x;
    logic [CW-1:0] p2y;
  } pts_t;

  typedef struct packed {
    logic [2:0] op;
    pts_t       pts;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  cmd_t           mem [fifo_depth];
  cmd_t           cmd_in;
  cmd_t           head;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]  level_q;
  logic           full, empty, push, pop, head_legal;

  state_t         state_q, state_d;
  logic [3:0]     write_q, write_d;
  pts_t           dest_q, dest_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [15:0]    done_q, done_d;
  logic           err_ill_q, err_ill_d, err_to_q, err_to_d;

  assign cmd_in     = '{op: cmd_op_i, pts: '{cmd_p0x_i, cmd_p0y_i, cmd_p1x_i, cmd_p1y_i, cmd_p2x_i, cmd_p2y_i}};
  assign head       = mem[rd_ptr_q];
  assign full       = (level_q == LW'(fifo_depth));
  assign empty      = (level_q == '0);
  assign push       = cmd_valid_i & ~full & ~flush_i;
  assign head_legal = (head.op >= 3'd1) && (head.op <= 3'd4);

  // Next-state and next-output logic; writes drop in IDLE/GAP so every ack is followed by a low cycle.
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    dest_d    = dest_q;
    wd_d      = wd_q;
    done_d    = done_q;
    err_ill_d = err_clr_i ? 1'b0 : err_ill_q;
    err_to_d  = err_clr_i ? 1'b0 : err_to_q;
    pop       = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        write_d = '0;
        state_d = IDLE;
        if (!empty) begin
          pop = 1'b1;
          if (head_legal) begin
            write_d = 4'(1) << (head.op - 3'd1);
            dest_d  = head.pts;
            wd_d    = '0;
            state_d = ISSUE;
          end else begin
            err_ill_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (raster_ack_i) begin
          write_d = '0;
          done_d  = done_q + 16'd1;
          state_d = GAP;
        end else begin
          // Saturating watchdog: the timeout event fires once, on the cycle the count reaches the limit.
          if (wd_q != WDW'(timeout_cycles)) wd_d = wd_q + WDW'(1);
          if ((timeout_cycles != 0) && (wd_q == WDW'(timeout_cycles - 1))) err_to_d = 1'b1;
        end
      end
      default: begin
        write_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      write_q   <= '0;
      dest_q    <= '0;
      wd_q      <= '0;
      done_q    <= '0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      dest_q    <= dest_d;
      wd_q      <= wd_d;
      done_q    <= done_d;
      err_ill_q <= err_ill_d;
      err_to_q  <= err_to_d;
    end
  end

  // FIFO pointers; flush drops any same-cycle push and empties whatever a same-cycle pop leaves.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= wr_ptr_q;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= cmd_in;
  end

  assign cmd_ready_o      = ~full;
  assign fifo_level_o     = level_q;
  assign busy_o           = (state_q != IDLE) | ~empty;
  assign point_write_o    = write_q[0];
  assign rect_write_o     = write_q[1];
  assign line_write_o     = write_q[2];
  assign triangle_write_o = write_q[3];
  assign dest_pixel0_x_o  = dest_q.p0x;
  assign dest_pixel0_y_o  = dest_q.p0y;
  assign dest_pixel1_x_o  = dest_q.p1x;
  assign dest_pixel1_y_o  = dest_q.p1y;
  assign dest_pixel2_x_o  = dest_q.p2x;
  assign dest_pixel2_y_o  = dest_q.p2y;
  assign done_cnt_o       = done_q;
  assign err_illegal_o    = err_ill_q;
  assign err_timeout_o    = err_to_q;

endmodule

// File: tb/tb_gfx_raster_cmd_sched.sv
// Bench for gfx_raster_cmd_sched: directed scenarios plus random traffic, compared every cycle
// against a queue-based reference model of the scheduler's command flow.
module tb_gfx_raster_cmd_sched;

  localparam int unsigned CW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int          TO    = 8;

  typedef struct packed {
    logic [2:0]         op;
    logic [5:0][CW-1:0] p;
  } ent_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i, cmd_ready_o, flush_i, err_clr_i, raster_ack_i;
  logic [2:0]    cmd_op_i;
  logic [CW-1:0] cin [6];
  logic          point_write_o, rect_write_o, line_write_o, triangle_write_o;
  logic [CW-1:0] d0x, d0y, d1x, d1y, d2x, d2y;
  logic          busy_o, err_illegal_o, err_timeout_o;
  logic [2:0]    fifo_level_o;
  logic [15:0]   done_cnt_o;

  always #5 clk_i = ~clk_i;

  gfx_raster_cmd_sched #(
    .point_width(16), .subpixel_width(16), .fifo_depth(DEPTH), .timeout_cycles(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_p0x_i(cin[0]), .cmd_p0y_i(cin[1]), .cmd_p1x_i(cin[2]),
    .cmd_p1y_i(cin[3]), .cmd_p2x_i(cin[4]), .cmd_p2y_i(cin[5]),
    .flush_i(flush_i), .err_clr_i(err_clr_i),
    .point_write_o(point_write_o), .rect_write_o(rect_write_o),
    .line_write_o(line_write_o), .triangle_write_o(triangle_write_o),
    .dest_pixel0_x_o(d0x), .dest_pixel0_y_o(d0y), .dest_pixel1_x_o(d1x),
    .dest_pixel1_y_o(d1y), .dest_pixel2_x_o(d2x), .dest_pixel2_y_o(d2y),
    .raster_ack_i(raster_ack_i), .busy_o(busy_o), .fifo_level_o(fifo_level_o),
    .done_cnt_o(done_cnt_o), .err_illegal_o(err_illegal_o), .err_timeout_o(err_timeout_o)
  );

  // Reference model: pending queue, the command being drawn, and the driver-visible counters.
  ent_t               q[$];
  int                 m_op;
  logic [5:0][CW-1:0] m_dst;
  bit                 m_inflight, m_gap, m_ill, m_to;
  int                 m_wd;
  logic [15:0]        m_done;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_op = 0; m_dst = '0; m_inflight = 0; m_gap = 0;
    m_wd = 0; m_done = '0; m_ill = 0; m_to = 0;
  endtask

  task automatic check_outputs();
    logic [5:0][CW-1:0] got;
    got = {d2y, d2x, d1y, d1x, d0y, d0x};
    check("ready", 64'(cmd_ready_o), 64'(q.size() < DEPTH));
    check("level", 64'(fifo_level_o), 64'(q.size()));
    check("writes", 64'({triangle_write_o, line_write_o, rect_write_o, point_write_o}),
          (m_op == 0) ? 64'd0 : (64'd1 << (m_op - 1)));
    for (int i = 0; i < 6; i++) check($sformatf("coord%0d", i), 64'(got[i]), 64'(m_dst[i]));
    check("busy", 64'(busy_o), 64'(m_inflight || m_gap || q.size() != 0));
    check("done", 64'(done_cnt_o), 64'(m_done));
    check("err_illegal", 64'(err_illegal_o), 64'(m_ill));
    check("err_timeout", 64'(err_timeout_o), 64'(m_to));
  endtask

  // One clock: drive inputs, advance the model, then compare just after the edge.
  task automatic step_cmd(input bit v, input logic [2:0] op, input logic [5:0][CW-1:0] p,
                          input bit fl, input bit clr, input bit ack);
    ent_t e;
    bit   ready, ill_ev, to_ev;
    e.op = op; e.p = p;
    cmd_valid_i = v; cmd_op_i = op; flush_i = fl; err_clr_i = clr; raster_ack_i = ack;
    for (int i = 0; i < 6; i++) cin[i] = p[i];
    ready = (q.size() < DEPTH); ill_ev = 0; to_ev = 0;
    if (m_inflight) begin
      m_wd++;
      if (ack) begin
        m_inflight = 0; m_op = 0; m_done = m_done + 16'd1; m_gap = 1;
      end else begin
        m_gap = 0;
        if (m_wd == TO) to_ev = 1;
      end
    end else begin
      m_gap = 0; m_op = 0;
      if (q.size() > 0) begin
        ent_t h;
        h = q.pop_front();
        if (h.op >= 3'd1 && h.op <= 3'd4) begin
          m_inflight = 1; m_op = int'(h.op); m_dst = h.p; m_wd = 0;
        end else begin
          ill_ev = 1;
        end
      end
    end
    if (fl) q.delete();
    else if (v && ready) q.push_back(e);
    m_ill = (clr ? 1'b0 : m_ill) | ill_ev;
    m_to  = (clr ? 1'b0 : m_to) | to_ev;
    @(posedge clk_i); #1;
    check_outputs();
  endtask

  task automatic step(input bit v, input logic [2:0] op, input bit fl, input bit clr, input bit ack);
    logic [5:0][CW-1:0] p;
    for (int i = 0; i < 6; i++) p[i] = CW'($urandom());
    step_cmd(v, op, p, fl, clr, ack);
  endtask

  task automatic drain(input int dly, input string tag);
    int n;
    n = 0;
    while ((m_inflight || m_gap || q.size() != 0) && n < 200) begin
      step(0, 3'd0, 0, 0, m_inflight && (m_wd == dly));
      n++;
    end
    check({tag, "_drained"}, 64'(n < 200), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [5:0][CW-1:0] p;
    logic [2:0] ill_ops [4];
    cmd_valid_i = 0; cmd_op_i = '0; flush_i = 0; err_clr_i = 0; raster_ack_i = 0;
    for (int i = 0; i < 6; i++) cin[i] = '0;
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs();
    check("rst_ready", 64'(cmd_ready_o), 64'd1);
    rst_i = 1'b0;

    // Single rect: write rises two cycles after the push, drops on the cycle after ack.
    p = '0;
    p[0] = 32'h0001_0000; p[1] = 32'h0002_0000; p[2] = 32'h0005_0000; p[3] = 32'h0006_0000;
    step_cmd(1, 3'd2, p, 0, 0, 0);
    check("t1_rect_t1", 64'(rect_write_o), 64'd0);
    step(0, 3'd0, 0, 0, 0);
    check("t1_rect_t2", 64'(rect_write_o), 64'd1);
    check("t1_p1x", 64'(d1x), 64'h0005_0000);
    check("t1_p0y", 64'(d0y), 64'h0002_0000);
    repeat (6) step(0, 3'd0, 0, 0, 0);
    step(0, 3'd0, 0, 0, 1);
    check("t1_low", 64'(rect_write_o), 64'd0);
    check("t1_done", 64'(done_cnt_o), 64'd1);
    check("t1_hold_p1x", 64'(d1x), 64'h0005_0000);
    step(0, 3'd0, 0, 0, 0);
    check("t1_idle", 64'(busy_o), 64'd0);

    // Fill the FIFO behind an in-flight command, then ack each 5 cycles after its write rises.
    step(1, 3'd3, 0, 0, 0);
    step(1, 3'd1, 0, 0, 0);
    step(1, 3'd4, 0, 0, 0);
    step(1, 3'd2, 0, 0, 0);
    step(1, 3'd1, 0, 0, 0);
    check("t2_full_level", 64'(fifo_level_o), 64'd4);
    check("t2_full_ready", 64'(cmd_ready_o), 64'd0);
    check("t2_line_first", 64'(line_write_o), 64'd1);
    drain(5, "t2");
    check("t2_done", 64'(done_cnt_o), 64'd6);

    // Illegal opcode is discarded and flagged; the following point still issues.
    step(1, 3'd6, 0, 0, 0);
    step(1, 3'd1, 0, 0, 0);
    check("t3_err", 64'(err_illegal_o), 64'd1);
    step(0, 3'd0, 0, 0, 0);
    check("t3_point", 64'(point_write_o), 64'd1);
    step(0, 3'd0, 0, 1, 0);
    check("t3_clr", 64'(err_illegal_o), 64'd0);
    drain(2, "t3");

    // Watchdog: no ack for more than 8 ISSUE cycles; command stays held, late ack completes it.
    step(1, 3'd1, 0, 0, 0);
    repeat (9) step(0, 3'd0, 0, 0, 0);
    check("t4_timeout", 64'(err_timeout_o), 64'd1);
    check("t4_held", 64'(point_write_o), 64'd1);
    repeat (9) step(0, 3'd0, 0, 0, 0);
    step(0, 3'd0, 0, 0, 1);
    check("t4_done", 64'(done_cnt_o), 64'd8);
    step(0, 3'd0, 0, 1, 0);
    check("t4_clr", 64'(err_timeout_o), 64'd0);
    drain(1, "t4");

    // Flush with one in flight and three queued: only the in-flight command completes.
    repeat (4) step(1, 3'($urandom_range(1, 4)), 0, 0, 0);
    check("t5_level", 64'(fifo_level_o), 64'd3);
    step(1, 3'd2, 1, 0, 0);
    check("t5_flushed", 64'(fifo_level_o), 64'd0);
    drain(3, "t5");
    repeat (3) step(0, 3'd0, 0, 0, 0);
    check("t5_done", 64'(done_cnt_o), 64'd9);

    // Asynchronous reset mid-cycle while a command is in flight.
    step(1, 3'd3, 0, 0, 0);
    step(1, 3'd1, 0, 0, 0);
    step(0, 3'd0, 0, 0, 0);
    #3 rst_i = 1'b1;
    #1;
    check("t6_write", 64'({triangle_write_o, line_write_o, rect_write_o, point_write_o}), 64'd0);
    check("t6_done", 64'(done_cnt_o), 64'd0);
    check("t6_level", 64'(fifo_level_o), 64'd0);
    check("t6_ready", 64'(cmd_ready_o), 64'd1);
    check("t6_coord", 64'(d0x), 64'd0);
    model_reset();
    cmd_valid_i = 0; raster_ack_i = 0;
    @(posedge clk_i); #1;
    check_outputs();
    rst_i = 1'b0;

    // Random traffic against the model.
    ill_ops[0] = 3'd0; ill_ops[1] = 3'd5; ill_ops[2] = 3'd6; ill_ops[3] = 3'd7;
    for (int n = 0; n < 2000; n++) begin
      logic [2:0] op;
      bit ack;
      op  = ($urandom_range(0, 99) < 85) ? 3'($urandom_range(1, 4)) : ill_ops[$urandom_range(0, 3)];
      ack = m_inflight ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
      step($urandom_range(0, 9) < 6, op, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5, ack);
    end
    drain(2, "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
